out_pair_qualifier: RTL and testbench

Downstream consumer of the combinational AND-OR stage's complementary pair `out`/`out_n`. It synchronises both signals into the `clk` domain and debounces `out` into a clean `level`. It emits one-cycle rise/fall pulses, keeps a saturating count of qualified rising edges, and flags a sticky error when the pair stops being complementary.

---
 rtl/out_pair_qualifier_pkg.sv | 18 +
 rtl/out_pair_qualifier_sync2.sv | 27 ++
 rtl/out_pair_qualifier.sv | 150 +++++++++++++++
 tb/tb_out_pair_qualifier.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_pair_qualifier_pkg.sv
// Shared types and constants for the out/out_n pair qualifier.
// Holds debounce state encoding and synchroniser reset values.
package out_pair_qualifier_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } dbnc_state_e;

  localparam int unsigned STABLE_CYCLES_DEF = 4;

  // out_n idles high so the pair is complementary out of reset
  localparam logic SYNC_OUT_RST   = 1'b0;
  localparam logic SYNC_OUT_N_RST = 1'b1;

endpackage

// File: rtl/out_pair_qualifier_sync2.sv
// Two-flop synchroniser with a configurable reset value.
// Used once for out and once for out_n.
module out_pair_qualifier_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/out_pair_qualifier.sv
// Synchronises and debounces the out/out_n pair, emits edge pulses,
// counts qualified rises and flags loss of complementarity.
module out_pair_qualifier
  import out_pair_qualifier_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             out_in,
  input  logic             out_n_in,
  input  logic             clr,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic             pair_err
);

  localparam int CW = (STABLE_CYCLES > 2) ?
                      $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RC_MAX = {CNT_W{1'b1}};

  logic s_out;
  logic s_out_n;

  out_pair_qualifier_sync2 #(
    .RST_VAL (SYNC_OUT_RST)
  ) u_sync_out (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_in),
    .q     (s_out)
  );

  out_pair_qualifier_sync2 #(
    .RST_VAL (SYNC_OUT_N_RST)
  ) u_sync_out_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_n_in),
    .q     (s_out_n)
  );

  dbnc_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             eq_q, eq_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (s_out) begin
          state_d = CHK_HI;
          cnt_d   = CW'(1);
        end
      end
      CHK_HI: begin
        if (!s_out) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!s_out) begin
          state_d = CHK_LO;
          cnt_d   = CW'(1);
        end
      end
      CHK_LO: begin
        if (s_out) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE_LO;
    endcase
  end

  // clr beats a same-cycle increment
  always_comb begin
    rc_d = rc_q;
    if (clr) begin
      rc_d = '0;
    end else if (rise_d && rc_q != RC_MAX) begin
      rc_d = rc_q + 1'b1;
    end
  end

  // a persisting fault re-sets the flag even while clr is high
  always_comb begin
    eq_d  = (s_out == s_out_n);
    err_d = err_q;
    if (eq_d && eq_q) begin
      err_d = 1'b1;
    end else if (clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      rc_q    <= '0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rc_q    <= rc_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign rise_count = rc_q;
  assign pair_err   = err_q;

endmodule

// File: tb/tb_out_pair_qualifier.sv
// Directed and random bench for out_pair_qualifier.
// Reference model tracks run lengths of the delayed input samples.
module tb_out_pair_qualifier;

  localparam int SC    = 4;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             out_in;
  logic             out_n_in;
  logic             clr;
  logic             level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_count;
  logic             pair_err;

  int n_cmp;
  int n_bad;

  int q_o[$];
  int q_on[$];
  int m_level, m_run, m_rise, m_fall;
  int m_cnt, m_err, m_eqp;

  out_pair_qualifier #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_in     (out_in),
    .out_n_in   (out_n_in),
    .clr        (clr),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_count (rise_count),
    .pair_err   (pair_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_o     = '{0, 0};
    q_on    = '{1, 1};
    m_level = 0;
    m_run   = 0;
    m_rise  = 0;
    m_fall  = 0;
    m_cnt   = 0;
    m_err   = 0;
    m_eqp   = 0;
  endtask

  // level flips once SC consecutive samples disagree with it
  task automatic model_step();
    int so, son, eq;
    if (!rst_n) begin
      model_reset();
      return;
    end
    so  = q_o.pop_front();
    son = q_on.pop_front();
    q_o.push_back(int'(out_in));
    q_on.push_back(int'(out_n_in));
    m_rise = 0;
    m_fall = 0;
    if (so != m_level) begin
      m_run++;
      if (m_run == SC) begin
        m_level = so;
        m_run   = 0;
        if (so == 1) m_rise = 1;
        else m_fall = 1;
      end
    end else begin
      m_run = 0;
    end
    if (clr) m_cnt = 0;
    else if (m_rise == 1 && m_cnt < MAXC) m_cnt++;
    eq = (so == son) ? 1 : 0;
    if (eq == 1 && m_eqp == 1) m_err = 1;
    else if (clr) m_err = 0;
    m_eqp = eq;
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(m_level));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    chk("rise_count", 32'(rise_count), 32'(m_cnt));
    chk("pair_err", 32'(pair_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic o, input logic on);
    out_in   = o;
    out_n_in = on;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b1);
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom));
      clr = 1'($urandom);
      tick();
      chk("rst_level", 32'(level), 0);
      chk("rst_rise", 32'(rise_pulse), 0);
      chk("rst_cnt", 32'(rise_count), 0);
      chk("rst_err", 32'(pair_err), 0);
    end
    clr = 1'b0;
    drive(1'b0, 1'b1);
    #2;
    rst_n = 1'b1;
    ticks(20);
    chk("idle_level", 32'(level), 0);
    chk("idle_cnt", 32'(rise_count), 0);

    // clean rise: first capture is the next edge
    drive(1'b1, 1'b0);
    ticks(5);
    chk("rise_early", 32'(level), 0);
    tick();
    chk("rise_level", 32'(level), 1);
    chk("rise_pulse", 32'(rise_pulse), 1);
    chk("rise_cnt1", 32'(rise_count), 1);
    tick();
    chk("rise_once", 32'(rise_pulse), 0);

    drive(1'b0, 1'b1);
    ticks(5);
    chk("fall_early", 32'(level), 1);
    tick();
    chk("fall_level", 32'(level), 0);
    chk("fall_pulse", 32'(fall_pulse), 1);
    chk("fall_cnt", 32'(rise_count), 1);
    ticks(4);

    // glitch of 3 samples is rejected
    drive(1'b1, 1'b0);
    ticks(3);
    drive(1'b0, 1'b1);
    ticks(10);
    chk("glitch_lvl", 32'(level), 0);
    chk("glitch_cnt", 32'(rise_count), 1);

    // 4-sample pulse is accepted
    drive(1'b1, 1'b0);
    ticks(4);
    drive(1'b0, 1'b1);
    ticks(2);
    chk("pulse4_lvl", 32'(level), 1);
    chk("pulse4_cnt", 32'(rise_count), 2);
    ticks(10);
    chk("pulse4_back", 32'(level), 0);

    // pair equal for one sample is tolerated
    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    ticks(6);
    chk("skew_ok", 32'(pair_err), 0);

    // pair equal for three samples latches the error
    drive(1'b1, 1'b1);
    ticks(3);
    drive(1'b0, 1'b1);
    ticks(6);
    chk("pair_err", 32'(pair_err), 1);
    ticks(5);
    chk("pair_sticky", 32'(pair_err), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("pair_clr", 32'(pair_err), 0);
    chk("clr_cnt", 32'(rise_count), 0);
    ticks(3);

    // saturation at 3 with CNT_W=2
    for (int r = 1; r <= 5; r++) begin
      drive(1'b1, 1'b0);
      ticks(6);
      chk("sat_cnt", 32'(rise_count),
          32'((r > MAXC) ? MAXC : r));
      drive(1'b0, 1'b1);
      ticks(7);
    end

    // clr on the qualifying edge wins
    drive(1'b1, 1'b0);
    ticks(5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("coll_pulse", 32'(rise_pulse), 1);
    chk("coll_cnt", 32'(rise_count), 0);
    drive(1'b0, 1'b1);
    ticks(8);

    // reset while qualifying a rise
    drive(1'b1, 1'b0);
    ticks(3);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_lvl", 32'(level), 0);
    chk("mid_rst_rise", 32'(rise_pulse), 0);
    ticks(2);
    #2;
    rst_n = 1'b1;
    ticks(5);
    chk("restart_lvl", 32'(level), 0);
    chk("restart_rise", 32'(rise_pulse), 0);
    tick();
    chk("requal_lvl", 32'(level), 1);
    chk("requal_rise", 32'(rise_pulse), 1);
    ticks(2);

    // random holds, occasional pair faults and clears
    for (int i = 0; i < 300; i++) begin
      logic o;
      int hold;
      o    = 1'($urandom);
      hold = $urandom_range(1, 8);
      drive(o, ($urandom_range(0, 9) == 0) ? o : ~o);
      for (int h = 0; h < hold; h++) begin
        clr = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
